// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple over WIDTH clock cycles with an IDLE/RUN/DONE FSM.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds input port sub).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_next;
    logic             c_load;
    logic             bit_s;
    logic             accept;
    logic             step;
    logic             last;

    // Operand B and carry seed as loaded on accept; subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // One full-adder slice per cycle; new bit enters the result MSB.
    assign bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign res_next   = (res_sh >> 1) | {bit_s, {(WIDTH-1){1'b0}}};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, carry, bit counter and held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b_load;
            res_sh <= '0;
            carry  <= c_load;
            cnt    <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= carry_next;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= res_next;
                cout <= carry_next;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases, randomized operations
// against an arithmetic reference, mid-RUN start/reset, back-to-back starts.
module tb_serial_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned W1 = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W:0]   prev;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; applies start, follows the whole operation and returns in the DONE cycle.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          input bit sb, input bit mid);
        logic [W:0] expv;
        if (sb) expv = {(ai >= bi), W'(ai - bi)};
        else    expv = W1'(ai) + W1'(bi) + W1'(ci);
        a = ai; b = bi; cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < int'(W); k++) begin
            start = mid && (k == 3);
            a     = mid && (k == 3) ? '0 : W'($urandom);
            b     = mid && (k == 3) ? '0 : W'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            check("busy_run", 32'(busy), 32'd1);
            check("done_low_run", 32'(done), 32'd0);
            check("result_hold", 32'({cout, sum}), 32'(prev));
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("result", 32'({cout, sum}), 32'(expv));
        prev = expv;
    endtask

    task automatic check_idle();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_idle_hold", 32'({cout, sum}), 32'(prev));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        prev = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'({cout, sum}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);

        // 0xFF + 0x01 wraps to 0x00 with carry out
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check_idle();
        // 0x5A + 0x3C + 1, with a start pulse mid-RUN that must be ignored
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b1);
        check_idle();
        // back-to-back: second start issued in the DONE cycle
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        check_idle();

        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) check_idle();
        end
        check_idle();

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        check_idle();
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
        check_idle();
        for (int n = 0; n < 8; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        check_idle();
`endif

        // Known non-zero result ahead of the reset-abort case
        run_op(8'h77, 8'h11, 1'b0, 1'b0, 1'b0);
        check_idle();

        // Reset three cycles into RUN aborts the operation asynchronously
        a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'({cout, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 32'd0);
            check("idle_after_abort", 32'(busy), 32'd0);
        end
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        check_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
